// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT peak detector.
package fft_pkg;

   localparam int N_FFT   = 8192;
   localparam int IDX_W   = 13;
   localparam int XK_W    = 38;
   localparam int MAG_W   = 48;
   localparam int SLICE_W = 24;
   localparam int SQ_W    = 47;

   typedef enum logic [2:0] {
      IDLE,
      UNLOAD,
      SCAN,
      DRAIN,
      REPORT
   } peak_state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage pipelined re^2 + im^2 on 24-bit signed slices, with valid and
// bin index carried alongside the data.
module fft_mag_sq
   import fft_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      valid_i,
   input  logic [IDX_W-1:0]          idx_i,
   input  logic signed [SLICE_W-1:0] re_i,
   input  logic signed [SLICE_W-1:0] im_i,
   output logic                      valid_o,
   output logic [IDX_W-1:0]          idx_o,
   output logic [MAG_W-1:0]          mag_o
);

   localparam int PROD_W = 2 * SLICE_W;

   logic signed [PROD_W-1:0] re_ext, im_ext, prod_re, prod_im;
   logic [SQ_W-1:0]          sq_re_q, sq_im_q;
   logic                     sq_valid_q;
   logic [IDX_W-1:0]         sq_idx_q;
   logic [MAG_W-1:0]         mag_d, mag_q;
   logic                     mag_valid_q;
   logic [IDX_W-1:0]         mag_idx_q;

   // A square is never negative and peaks at 2^46, so 47 unsigned bits hold it.
   assign re_ext  = PROD_W'(re_i);
   assign im_ext  = PROD_W'(im_i);
   assign prod_re = re_ext * re_ext;
   assign prod_im = im_ext * im_ext;
   assign mag_d   = {1'b0, sq_re_q} + {1'b0, sq_im_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_valid_q  <= 1'b0;
         sq_idx_q    <= '0;
         sq_re_q     <= '0;
         sq_im_q     <= '0;
         mag_valid_q <= 1'b0;
         mag_idx_q   <= '0;
         mag_q       <= '0;
      end else begin
         sq_valid_q  <= valid_i;
         sq_idx_q    <= idx_i;
         sq_re_q     <= prod_re[SQ_W-1:0];
         sq_im_q     <= prod_im[SQ_W-1:0];
         mag_valid_q <= sq_valid_q;
         mag_idx_q   <= sq_idx_q;
         mag_q       <= mag_d;
      end
   end

   assign valid_o = mag_valid_q;
   assign idx_o   = mag_idx_q;
   assign mag_o   = mag_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Unloads one FFT frame, finds the largest |X|^2 bin inside [MIN_BIN, MAX_BIN]
// and reports it once per frame. FFT_PEAK_THRESH_EN adds a threshold flag.
module fft_peak_detect
   import fft_pkg::*;
#(
   parameter int MIN_BIN   = 1,
   parameter int MAX_BIN   = 4095,
   parameter int TRUNC_LSB = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    done,
   input  logic                    dv,
   input  logic [IDX_W-1:0]        xk_index,
   input  logic signed [XK_W-1:0]  xk_re,
   input  logic signed [XK_W-1:0]  xk_im,
`ifdef FFT_PEAK_THRESH_EN
   input  logic [MAG_W-1:0]        thresh,
   output logic                    peak_above,
`endif
   output logic                    unload,
   output logic                    busy,
   output logic                    peak_valid,
   output logic [IDX_W-1:0]        peak_index,
   output logic [MAG_W-1:0]        peak_mag
);

   localparam logic [IDX_W-1:0] MIN_IDX  = IDX_W'(MIN_BIN);
   localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(MAX_BIN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FFT - 1);

   peak_state_t              state_q;
   logic [1:0]               drain_cnt_q;
   logic                     unload_q, busy_q, peak_valid_q;
   logic [IDX_W-1:0]         peak_index_q, best_idx_q, best_idx_d;
   logic [MAG_W-1:0]         peak_mag_q, best_mag_q, best_mag_d;
   logic                     s1_valid_q;
   logic [IDX_W-1:0]         s1_idx_q;
   logic signed [SLICE_W-1:0] s1_re_q, s1_im_q;
   logic                     m_valid;
   logic [IDX_W-1:0]         m_idx;
   logic [MAG_W-1:0]         m_mag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         s1_re_q    <= '0;
         s1_im_q    <= '0;
      end else begin
         s1_valid_q <= dv && (state_q == SCAN);
         s1_idx_q   <= xk_index;
         s1_re_q    <= xk_re[TRUNC_LSB +: SLICE_W];
         s1_im_q    <= xk_im[TRUNC_LSB +: SLICE_W];
      end
   end

   fft_mag_sq u_mag_sq (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (s1_valid_q),
      .idx_i   (s1_idx_q),
      .re_i    (s1_re_q),
      .im_i    (s1_im_q),
      .valid_o (m_valid),
      .idx_o   (m_idx),
      .mag_o   (m_mag)
   );

   // Strictly-greater update keeps the lowest index on ties.
   always_comb begin
      best_mag_d = best_mag_q;
      best_idx_d = best_idx_q;
      if (m_valid && (m_idx >= MIN_IDX) && (m_idx <= MAX_IDX) && (m_mag > best_mag_q)) begin
         best_mag_d = m_mag;
         best_idx_d = m_idx;
      end
   end

   // The last bin reaches the comparator in the final DRAIN cycle, so the
   // report latches best_*_d rather than the registered best.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         drain_cnt_q  <= '0;
         unload_q     <= 1'b0;
         busy_q       <= 1'b0;
         peak_valid_q <= 1'b0;
         peak_index_q <= '0;
         peak_mag_q   <= '0;
         best_idx_q   <= '0;
         best_mag_q   <= '0;
`ifdef FFT_PEAK_THRESH_EN
         peak_above   <= 1'b0;
`endif
      end else begin
         unload_q     <= 1'b0;
         peak_valid_q <= 1'b0;
         best_idx_q   <= best_idx_d;
         best_mag_q   <= best_mag_d;
         case (state_q)
            IDLE: begin
               if (done) begin
                  state_q  <= UNLOAD;
                  unload_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            UNLOAD: begin
               best_mag_q <= '0;
               best_idx_q <= MIN_IDX;
               state_q    <= SCAN;
            end
            SCAN: begin
               if (dv && (xk_index == LAST_IDX)) begin
                  state_q     <= DRAIN;
                  drain_cnt_q <= '0;
               end
            end
            DRAIN: begin
               if (drain_cnt_q == 2'd2) begin
                  state_q      <= REPORT;
                  peak_valid_q <= 1'b1;
                  peak_index_q <= best_idx_d;
                  peak_mag_q   <= best_mag_d;
`ifdef FFT_PEAK_THRESH_EN
                  peak_above   <= (best_mag_d >= thresh);
`endif
               end else begin
                  drain_cnt_q <= drain_cnt_q + 2'd1;
               end
            end
            REPORT: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign unload     = unload_q;
   assign busy       = busy_q;
   assign peak_valid = peak_valid_q;
   assign peak_index = peak_index_q;
   assign peak_mag   = peak_mag_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: full 8192-bin frames built from a
// sparse slice table, with a posedge monitor recording strobes and latency.
module tb_fft_peak_detect;
   import fft_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   done;
   logic                   dv;
   logic [IDX_W-1:0]       xk_index;
   logic signed [XK_W-1:0] xk_re, xk_im;
   logic                   unload, busy, peak_valid;
   logic [IDX_W-1:0]       peak_index;
   logic [MAG_W-1:0]       peak_mag;
`ifdef FFT_PEAK_THRESH_EN
   logic [MAG_W-1:0]       thresh;
   logic                   peak_above;
`endif

   fft_peak_detect dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .done       (done),
      .dv         (dv),
      .xk_index   (xk_index),
      .xk_re      (xk_re),
      .xk_im      (xk_im),
`ifdef FFT_PEAK_THRESH_EN
      .thresh     (thresh),
      .peak_above (peak_above),
`endif
      .unload     (unload),
      .busy       (busy),
      .peak_valid (peak_valid),
      .peak_index (peak_index),
      .peak_mag   (peak_mag)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic signed [SLICE_W-1:0] sl_re [N_FFT];
   logic signed [SLICE_W-1:0] sl_im [N_FFT];

   int               cyc = 0;
   int               unload_cnt = 0, unload_cyc = 0;
   int               pv_cnt = 0, pv_cyc = 0;
   logic [IDX_W-1:0] pv_idx;
   logic [MAG_W-1:0] pv_mag;
   logic             pv_busy;
   int               done_cyc, last_cyc, busy_low_cnt;
   bit               timed_out;

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (unload === 1'b1) begin
         unload_cnt = unload_cnt + 1;
         unload_cyc = cyc;
      end
      if (peak_valid === 1'b1) begin
         pv_cnt  = pv_cnt + 1;
         pv_cyc  = cyc;
         pv_idx  = peak_index;
         pv_mag  = peak_mag;
         pv_busy = busy;
      end
   end

   task automatic clear_bins();
      for (int i = 0; i < N_FFT; i++) begin
         sl_re[i] = '0;
         sl_im[i] = '0;
      end
   endtask

   task automatic run_frame(input bit gappy, input int abort_at, input bit mid_done);
      int pv0;
      pv0 = pv_cnt;
      busy_low_cnt = 0;
      timed_out = 1'b0;
      @(negedge clk);
      done = 1'b1;
      done_cyc = cyc;
      @(negedge clk);
      done = 1'b0;
      // UNLOAD cycle: a huge in-window bin that must be ignored
      dv = 1'b1;
      xk_index = 13'd50;
      xk_re = {24'sd4000000, 14'd0};
      xk_im = '0;
      @(negedge clk);
      for (int i = 0; i < N_FFT; i++) begin
         if (gappy && (i % 2 == 1)) begin
            dv = 1'b0;
            done = 1'b0;
            xk_index = 13'($urandom_range(0, N_FFT - 1));
            xk_re = 38'($urandom);
            xk_im = 38'($urandom);
            @(negedge clk);
            if (busy !== 1'b1) busy_low_cnt++;
         end
         dv = 1'b1;
         xk_index = 13'(i);
         xk_re = {sl_re[i], 14'($urandom_range(0, 16383))};
         xk_im = {sl_im[i], 14'($urandom_range(0, 16383))};
         done = (mid_done && i == 1000);
         if (i == abort_at) rst_n = 1'b0;
         last_cyc = cyc;
         @(negedge clk);
         if (i == abort_at) begin
            dv = 1'b0;
            done = 1'b0;
            return;
         end
         if (busy !== 1'b1) busy_low_cnt++;
      end
      dv = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 20 && pv_cnt == pv0; k++) @(negedge clk);
      if (pv_cnt == pv0) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; done = 1'b0; dv = 1'b0; xk_index = '0; xk_re = '0; xk_im = '0;
`ifdef FFT_PEAK_THRESH_EN
      thresh = '0;
`endif
      repeat (3) @(negedge clk);
      n_checks++; if (unload !== 1'b0) $display("FAIL reset_unload got=%b exp=0", unload); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (peak_valid !== 1'b0) $display("FAIL reset_peak_valid got=%b exp=0", peak_valid); else n_pass++;
      n_checks++; if (peak_index !== 13'd0) $display("FAIL reset_peak_index got=%0d exp=0", peak_index); else n_pass++;
      n_checks++; if (peak_mag !== 48'd0) $display("FAIL reset_peak_mag got=%0d exp=0", peak_mag); else n_pass++;
`ifdef FFT_PEAK_THRESH_EN
      n_checks++; if (peak_above !== 1'b0) $display("FAIL reset_peak_above got=%b exp=0", peak_above); else n_pass++;
`endif
   endtask

   task automatic test_tone();
      int u0, p0;
      clear_bins();
      sl_re[100] = 24'sd1000;
`ifdef FFT_PEAK_THRESH_EN
      thresh = 48'd1000000;
`endif
      u0 = unload_cnt; p0 = pv_cnt;
      run_frame(1'b0, -1, 1'b0);
      n_checks++; if (timed_out) $display("FAIL tone_timeout got=no_peak_valid exp=peak_valid"); else n_pass++;
      n_checks++; if (unload_cnt - u0 != 1) $display("FAIL tone_unload_count got=%0d exp=1", unload_cnt - u0); else n_pass++;
      n_checks++; if (unload_cyc != done_cyc + 1) $display("FAIL tone_unload_latency got=%0d exp=1", unload_cyc - done_cyc); else n_pass++;
      n_checks++; if (pv_cyc != last_cyc + 4) $display("FAIL tone_pv_latency got=%0d exp=4", pv_cyc - last_cyc); else n_pass++;
      n_checks++; if (pv_idx !== 13'd100) $display("FAIL tone_index got=%0d exp=100", pv_idx); else n_pass++;
      n_checks++; if (pv_mag !== 48'd1000000) $display("FAIL tone_mag got=%0d exp=1000000", pv_mag); else n_pass++;
      n_checks++; if (pv_busy !== 1'b1) $display("FAIL tone_busy_at_pv got=%b exp=1", pv_busy); else n_pass++;
      n_checks++; if (busy_low_cnt != 0) $display("FAIL tone_busy_scan got=%0d_low exp=0_low", busy_low_cnt); else n_pass++;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL tone_busy_after got=%b exp=0", busy); else n_pass++;
      n_checks++; if (peak_valid !== 1'b0) $display("FAIL tone_pv_one_cycle got=%b exp=0", peak_valid); else n_pass++;
      n_checks++; if (peak_index !== 13'd100) $display("FAIL tone_index_held got=%0d exp=100", peak_index); else n_pass++;
      n_checks++; if (pv_cnt - p0 != 1) $display("FAIL tone_pv_count got=%0d exp=1", pv_cnt - p0); else n_pass++;
`ifdef FFT_PEAK_THRESH_EN
      n_checks++; if (peak_above !== 1'b1) $display("FAIL thresh_equal got=%b exp=1", peak_above); else n_pass++;
`endif
   endtask

   task automatic test_window();
      clear_bins();
      sl_re[0] = 24'sd5000;
      sl_re[5000] = 24'sd6000;
      sl_re[200] = 24'sd10;
      run_frame(1'b0, -1, 1'b0);
      n_checks++; if (timed_out) $display("FAIL window_timeout got=no_peak_valid exp=peak_valid"); else n_pass++;
      n_checks++; if (pv_idx !== 13'd200) $display("FAIL window_index got=%0d exp=200", pv_idx); else n_pass++;
      n_checks++; if (pv_mag !== 48'd100) $display("FAIL window_mag got=%0d exp=100", pv_mag); else n_pass++;
   endtask

   task automatic test_tie_sign();
      clear_bins();
      sl_re[300] = -24'sd50; sl_im[300] = 24'sd50;
      sl_re[700] = -24'sd50; sl_im[700] = 24'sd50;
      run_frame(1'b0, -1, 1'b0);
      n_checks++; if (timed_out) $display("FAIL tie_timeout got=no_peak_valid exp=peak_valid"); else n_pass++;
      n_checks++; if (pv_idx !== 13'd300) $display("FAIL tie_index got=%0d exp=300", pv_idx); else n_pass++;
      n_checks++; if (pv_mag !== 48'd5000) $display("FAIL tie_mag got=%0d exp=5000", pv_mag); else n_pass++;
   endtask

   task automatic test_boundary();
      clear_bins();
      sl_re[0] = 24'sd40;
      sl_re[1] = 24'sd19;
      sl_re[4095] = 24'sd20;
      sl_re[4096] = 24'sd30;
      run_frame(1'b0, -1, 1'b0);
      n_checks++; if (timed_out) $display("FAIL edge_timeout got=no_peak_valid exp=peak_valid"); else n_pass++;
      n_checks++; if (pv_idx !== 13'd4095) $display("FAIL edge_index got=%0d exp=4095", pv_idx); else n_pass++;
      n_checks++; if (pv_mag !== 48'd400) $display("FAIL edge_mag got=%0d exp=400", pv_mag); else n_pass++;
   endtask

   task automatic test_zero_window();
      clear_bins();
      sl_re[0] = 24'sd5000;
      sl_re[4096] = 24'sd5000;
      sl_im[8191] = 24'sd7;
      run_frame(1'b0, -1, 1'b0);
      n_checks++; if (timed_out) $display("FAIL zero_timeout got=no_peak_valid exp=peak_valid"); else n_pass++;
      n_checks++; if (pv_idx !== 13'd1) $display("FAIL zero_index got=%0d exp=1", pv_idx); else n_pass++;
      n_checks++; if (pv_mag !== 48'd0) $display("FAIL zero_mag got=%0d exp=0", pv_mag); else n_pass++;
   endtask

   task automatic test_gappy();
      clear_bins();
      sl_re[9] = 24'sd1000;
      run_frame(1'b1, -1, 1'b0);
      n_checks++; if (timed_out) $display("FAIL gappy_timeout got=no_peak_valid exp=peak_valid"); else n_pass++;
      n_checks++; if (pv_idx !== 13'd9) $display("FAIL gappy_index got=%0d exp=9", pv_idx); else n_pass++;
      n_checks++; if (pv_mag !== 48'd1000000) $display("FAIL gappy_mag got=%0d exp=1000000", pv_mag); else n_pass++;
      n_checks++; if (busy_low_cnt != 0) $display("FAIL gappy_busy got=%0d_low exp=0_low", busy_low_cnt); else n_pass++;
      n_checks++; if (pv_busy !== 1'b1) $display("FAIL gappy_busy_at_pv got=%b exp=1", pv_busy); else n_pass++;
      n_checks++; if (pv_cyc != last_cyc + 4) $display("FAIL gappy_pv_latency got=%0d exp=4", pv_cyc - last_cyc); else n_pass++;
   endtask

   task automatic test_abort();
      int p0, u0;
      clear_bins();
      sl_re[100] = 24'sd1000;
      p0 = pv_cnt;
      run_frame(1'b0, 4000, 1'b0);
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (peak_index !== 13'd0) $display("FAIL abort_peak_index got=%0d exp=0", peak_index); else n_pass++;
      n_checks++; if (peak_mag !== 48'd0) $display("FAIL abort_peak_mag got=%0d exp=0", peak_mag); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      n_checks++; if (pv_cnt != p0) $display("FAIL abort_no_pv got=%0d exp=0", pv_cnt - p0); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle_busy got=%b exp=0", busy); else n_pass++;
      clear_bins();
      sl_re[17] = 24'sd300; sl_im[17] = -24'sd400;
      u0 = unload_cnt; p0 = pv_cnt;
      run_frame(1'b0, -1, 1'b1);
      n_checks++; if (timed_out) $display("FAIL abort2_timeout got=no_peak_valid exp=peak_valid"); else n_pass++;
      n_checks++; if (unload_cnt - u0 != 1) $display("FAIL abort2_unload_count got=%0d exp=1", unload_cnt - u0); else n_pass++;
      n_checks++; if (pv_cnt - p0 != 1) $display("FAIL abort2_pv_count got=%0d exp=1", pv_cnt - p0); else n_pass++;
      n_checks++; if (pv_idx !== 13'd17) $display("FAIL abort2_index got=%0d exp=17", pv_idx); else n_pass++;
      n_checks++; if (pv_mag !== 48'd250000) $display("FAIL abort2_mag got=%0d exp=250000", pv_mag); else n_pass++;
   endtask

`ifdef FFT_PEAK_THRESH_EN
   task automatic test_thresh();
      clear_bins();
      sl_re[100] = 24'sd1000;
      thresh = 48'd1000001;
      run_frame(1'b0, -1, 1'b0);
      @(negedge clk);
      n_checks++; if (timed_out) $display("FAIL thresh_timeout got=no_peak_valid exp=peak_valid"); else n_pass++;
      n_checks++; if (peak_above !== 1'b0) $display("FAIL thresh_above got=%b exp=0", peak_above); else n_pass++;
      n_checks++; if (peak_mag !== 48'd1000000) $display("FAIL thresh_mag got=%0d exp=1000000", peak_mag); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_tone();
      test_window();
      test_tie_sign();
      test_boundary();
      test_zero_window();
      test_gappy();
      test_abort();
`ifdef FFT_PEAK_THRESH_EN
      test_thresh();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
